// File: rtl/minc_mem_arbiter.sv
// Shares the minc program/stack RAM between fetch (F), stack (S) and loader (L).
// Loader has fixed priority; F and S alternate round-robin when both request.
module minc_mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          nRESET,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic [DW-1:0] f_rdata,
  input  logic          s_req,
  input  logic          s_we,
  input  logic [AW-1:0] s_addr,
  input  logic [DW-1:0] s_wdata,
  output logic          s_ack,
  output logic [DW-1:0] s_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_ack,
  output logic [DW-1:0] l_rdata,
  input  logic          l_hold,
  output logic          cpu_stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_F    = 2'd1,
    OWN_S    = 2'd2,
    OWN_L    = 2'd3
  } owner_t;

  state_t          state_q, state_d;
  owner_t          owner_q, owner_d;
  owner_t          rr_last_q, rr_last_d;
  owner_t          grant_s;
  logic            stall_q;
  logic [DW-1:0]   f_rdata_q, s_rdata_q, l_rdata_q;
  logic            mem_en_s, mem_we_s;
  logic [AW-1:0]   mem_addr_s;
  logic [DW-1:0]   mem_wdata_s;
  logic            f_ack_s, s_ack_s, l_ack_s;

  // Winner selection; l_hold freezes CPU requesters even with no loader access pending
  always_comb begin
    grant_s = OWN_NONE;
    if (l_req) begin
      grant_s = OWN_L;
    end else if (!l_hold) begin
      if (f_req && s_req) begin
        grant_s = (rr_last_q == OWN_F) ? OWN_S : OWN_F;
      end else if (f_req) begin
        grant_s = OWN_F;
      end else if (s_req) begin
        grant_s = OWN_S;
      end else begin
        grant_s = OWN_NONE;
      end
    end else begin
      grant_s = OWN_NONE;
    end
  end

  // Next-state logic and the combinational RAM strobe issued from IDLE
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_last_d   = rr_last_q;
    mem_en_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = '0;
    mem_wdata_s = '0;
    case (state_q)
      IDLE: begin
        if (grant_s != OWN_NONE) begin
          mem_en_s = 1'b1;
          state_d  = BUSY;
          owner_d  = grant_s;
          if (grant_s != OWN_L) begin
            rr_last_d = grant_s;
          end else begin
            rr_last_d = rr_last_q;
          end
          case (grant_s)
            OWN_F: begin
              mem_addr_s = f_addr;
            end
            OWN_S: begin
              mem_we_s    = s_we;
              mem_addr_s  = s_addr;
              mem_wdata_s = s_wdata;
            end
            OWN_L: begin
              mem_we_s    = l_we;
              mem_addr_s  = l_addr;
              mem_wdata_s = l_wdata;
            end
            default: begin
              mem_en_s = 1'b0;
            end
          endcase
        end else begin
          owner_d = OWN_NONE;
        end
      end
      BUSY: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  assign f_ack_s = (state_q == BUSY) && (owner_q == OWN_F);
  assign s_ack_s = (state_q == BUSY) && (owner_q == OWN_S);
  assign l_ack_s = (state_q == BUSY) && (owner_q == OWN_L);

  // Gate the strobe so nothing reaches the RAM while reset is asserted
  assign mem_en    = mem_en_s & ~nRESET;
  assign mem_we    = mem_we_s & ~nRESET;
  assign mem_addr  = nRESET ? '0 : mem_addr_s;
  assign mem_wdata = nRESET ? '0 : mem_wdata_s;

  assign f_ack     = f_ack_s;
  assign s_ack     = s_ack_s;
  assign l_ack     = l_ack_s;
  assign f_rdata   = f_ack_s ? mem_rdata : f_rdata_q;
  assign s_rdata   = s_ack_s ? mem_rdata : s_rdata_q;
  assign l_rdata   = l_ack_s ? mem_rdata : l_rdata_q;
  assign cpu_stall = stall_q;

  // Arbiter state, round-robin history, stall flag and per-requester read data
  always_ff @(posedge CLK or posedge nRESET) begin
    if (nRESET) begin
      state_q   <= IDLE;
      owner_q   <= OWN_NONE;
      rr_last_q <= OWN_F;
      stall_q   <= 1'b0;
      f_rdata_q <= '0;
      s_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      stall_q   <= l_hold | l_ack_s;
      f_rdata_q <= f_ack_s ? mem_rdata : f_rdata_q;
      s_rdata_q <= s_ack_s ? mem_rdata : s_rdata_q;
      l_rdata_q <= l_ack_s ? mem_rdata : l_rdata_q;
    end
  end

endmodule

// File: tb/tb_minc_mem_arbiter.sv
// Directed bench for minc_mem_arbiter: a table of single transactions plus
// hand-written loader/stall and reset-during-access sequences.
module tb_minc_mem_arbiter;

  logic       CLK, nRESET;
  logic       f_req, f_ack;
  logic [7:0] f_addr, f_rdata;
  logic       s_req, s_we, s_ack;
  logic [7:0] s_addr, s_wdata, s_rdata;
  logic       l_req, l_we, l_ack, l_hold, cpu_stall;
  logic [7:0] l_addr, l_wdata, l_rdata;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  logic [7:0] ram [0:255];
  int         n_pass = 0;
  int         n_total = 0;

  minc_mem_arbiter #(.AW(8), .DW(8)) dut (
    .CLK(CLK), .nRESET(nRESET),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_ack(l_ack), .l_rdata(l_rdata), .l_hold(l_hold), .cpu_stall(cpu_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronous single-port RAM model
  always @(posedge CLK) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  typedef struct {
    logic       lh, lr, lwe, fr, sr, swe;
    logic [7:0] la, fa, sa, wd;
    logic       exp_en, exp_we;
    logic [7:0] exp_addr;
    logic [1:0] exp_ack;   // 0 none, 1 F, 2 S, 3 L
    logic       chk_rd;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act !== exp_v) $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    else n_pass++;
  endtask

  function automatic vec_t mk(input logic lh, lr, lwe, fr, sr, swe,
                              input logic [7:0] la, fa, sa, wd,
                              input logic en, we, input logic [7:0] addr,
                              input logic [1:0] ack, input logic crd,
                              input logic [7:0] rd);
    vec_t v;
    v.lh = lh; v.lr = lr; v.lwe = lwe; v.fr = fr; v.sr = sr; v.swe = swe;
    v.la = la; v.fa = fa; v.sa = sa; v.wd = wd;
    v.exp_en = en; v.exp_we = we; v.exp_addr = addr;
    v.exp_ack = ack; v.chk_rd = crd; v.exp_rd = rd;
    return v;
  endfunction

  task automatic idle_inputs();
    f_req = 1'b0; s_req = 1'b0; l_req = 1'b0; l_hold = 1'b0;
    s_we = 1'b0; l_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rd;
    bit seen;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[8'h10] = 8'hA5; ram[8'h20] = 8'h11; ram[8'h30] = 8'hC3; ram[8'h40] = 8'h5A;
    mem_rdata = 8'h00;
    f_addr = 8'h00; s_addr = 8'h00; s_wdata = 8'h00; l_addr = 8'h00; l_wdata = 8'h00;
    idle_inputs();

    // rr_last starts at F; expected grants traced by hand through the table
    vecs[0] = mk(0,0,0, 1,0,0, 8'h00,8'h10,8'h00,8'h00, 1,0,8'h10, 2'd1,1,8'hA5);
    vecs[1] = mk(0,0,0, 0,1,0, 8'h00,8'h00,8'h20,8'h00, 1,0,8'h20, 2'd2,1,8'h11);
    vecs[2] = mk(0,0,0, 1,1,0, 8'h00,8'h30,8'h40,8'h00, 1,0,8'h30, 2'd1,1,8'hC3);
    vecs[3] = mk(0,0,0, 1,1,0, 8'h00,8'h30,8'h40,8'h00, 1,0,8'h40, 2'd2,1,8'h5A);
    vecs[4] = mk(0,1,0, 1,1,0, 8'h10,8'h30,8'h40,8'h00, 1,0,8'h10, 2'd3,1,8'hA5);
    vecs[5] = mk(0,0,0, 1,1,0, 8'h00,8'h30,8'h40,8'h00, 1,0,8'h30, 2'd1,1,8'hC3);
    vecs[6] = mk(1,0,0, 1,1,0, 8'h00,8'h30,8'h40,8'h00, 0,0,8'h00, 2'd0,0,8'h00);
    vecs[7] = mk(0,0,0, 0,1,1, 8'h00,8'h00,8'hFF,8'h7E, 1,1,8'hFF, 2'd2,0,8'h00);
    vecs[8] = mk(0,0,0, 0,1,0, 8'h00,8'h00,8'hFF,8'h00, 1,0,8'hFF, 2'd2,1,8'h7E);
    vecs[9] = mk(0,0,0, 1,1,0, 8'h00,8'h10,8'h40,8'h00, 1,0,8'h10, 2'd1,1,8'hA5);

    // Reset held two cycles
    nRESET = 1'b1;
    @(posedge CLK); @(posedge CLK);
    @(negedge CLK); nRESET = 1'b0;
    #1;
    chk("reset_acks", {f_ack, s_ack, l_ack}, 3'b000);
    chk("reset_mem_en", mem_en, 1'b0);
    chk("reset_stall", cpu_stall, 1'b0);
    chk("reset_rdata", {f_rdata, s_rdata, l_rdata}, 24'h0);

    // Table of single transactions
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      l_hold = vecs[i].lh; l_req = vecs[i].lr; l_we = vecs[i].lwe; l_addr = vecs[i].la;
      l_wdata = vecs[i].wd; f_req = vecs[i].fr; f_addr = vecs[i].fa;
      s_req = vecs[i].sr; s_we = vecs[i].swe; s_addr = vecs[i].sa; s_wdata = vecs[i].wd;
      #1;
      chk($sformatf("v%0d_mem_en", i), mem_en, vecs[i].exp_en);
      if (vecs[i].exp_en) begin
        chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].exp_addr);
        chk($sformatf("v%0d_mem_we", i), mem_we, vecs[i].exp_we);
        if (vecs[i].exp_we) chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].wd);
      end
      @(negedge CLK); #1;
      chk($sformatf("v%0d_acks", i), {l_ack, s_ack, f_ack},
          {vecs[i].exp_ack == 2'd3, vecs[i].exp_ack == 2'd2, vecs[i].exp_ack == 2'd1});
      if (vecs[i].chk_rd) begin
        case (vecs[i].exp_ack)
          2'd1:    rd = f_rdata;
          2'd2:    rd = s_rdata;
          default: rd = l_rdata;
        endcase
        chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      end
      idle_inputs();
    end

    // Read data holds per requester once acks are gone
    @(negedge CLK); @(negedge CLK); #1;
    chk("hold_f_rdata", f_rdata, 8'hA5);
    chk("hold_s_rdata", s_rdata, 8'h7E);
    chk("hold_l_rdata", l_rdata, 8'hA5);
    chk("ram_ff_written", ram[8'hFF], 8'h7E);

    // Loader session: write 0x3C to 0x05 while fetch waits
    @(negedge CLK);
    l_hold = 1'b1; l_req = 1'b1; l_we = 1'b1; l_addr = 8'h05; l_wdata = 8'h3C;
    f_req = 1'b1; f_addr = 8'h05;
    #1;
    chk("ld_mem_en", mem_en, 1'b1);
    chk("ld_mem_addr", mem_addr, 8'h05);
    chk("ld_mem_we", mem_we, 1'b1);
    @(negedge CLK);
    l_req = 1'b0; l_we = 1'b0;
    #1;
    chk("ld_l_ack", l_ack, 1'b1);
    chk("ld_f_ack_masked", f_ack, 1'b0);
    chk("ld_stall", cpu_stall, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK); #1;
      chk($sformatf("ld_hold%0d_f_ack", c), {f_ack, mem_en}, 2'b00);
      chk($sformatf("ld_hold%0d_stall", c), cpu_stall, 1'b1);
    end
    chk("ld_ram_05", ram[8'h05], 8'h3C);
    @(negedge CLK);
    l_hold = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 2 && !seen; c++) begin
      @(negedge CLK); #1;
      if (f_ack) begin
        seen = 1'b1;
        chk("ld_f_rdata", f_rdata, 8'h3C);
        chk("ld_stall_clear", cpu_stall, 1'b0);
      end
    end
    chk("ld_f_ack_after_release", seen, 1'b1);
    idle_inputs();

    // Reset during a fetch's BUSY cycle abandons it; the held request retries
    @(negedge CLK); @(negedge CLK);
    f_req = 1'b1; f_addr = 8'h20;
    @(negedge CLK);
    nRESET = 1'b1;
    #1;
    chk("rst_busy_f_ack", f_ack, 1'b0);
    chk("rst_busy_f_rdata", f_rdata, 8'h00);
    chk("rst_busy_mem_en", mem_en, 1'b0);
    @(negedge CLK);
    nRESET = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 3 && !seen; c++) begin
      @(negedge CLK); #1;
      if (f_ack) begin
        seen = 1'b1;
        chk("rst_retry_f_rdata", f_rdata, 8'h11);
      end
    end
    chk("rst_retry_f_ack", seen, 1'b1);
    idle_inputs();

    @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
